// File: rtl/aurora_tx_arb_pkg.sv
// Shared FSM state type, configuration limits and round-robin search helper
// for the Aurora TX port arbiter.
package aurora_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS   = 2'd1,
    ST_PAUSED = 2'd2
  } arb_state_e;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;
  localparam int NUM_CHDR_W = 4;
  localparam int CHDR_W_LIST [NUM_CHDR_W] = '{64, 128, 256, 512};

  typedef struct packed {
    logic                  found;
    logic [PORT_IDX_W-1:0] port;
  } rr_pick_t;

  function automatic bit chdr_w_legal(input int w);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < NUM_CHDR_W; k++)
      if (CHDR_W_LIST[k] == w) ok = 1'b1;
    return ok;
  endfunction

  // Walks last_grant+1, +2, ... and returns the first requester; scanning from
  // the far end lets the nearest hit overwrite earlier ones.
  function automatic rr_pick_t next_rr_port(input logic [MAX_PORTS-1:0]  req_mask,
                                            input logic [PORT_IDX_W-1:0] last_grant,
                                            input int                    num_ports);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= num_ports) begin
        idx = (int'(last_grant) + k) % num_ports;
        if (req_mask[idx[PORT_IDX_W-1:0]]) begin
          pick.found = 1'b1;
          pick.port  = idx[PORT_IDX_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/aurora_tx_out_reg.sv
// Single-entry registered valid/ready stage driving the merged Aurora TX stream.
module aurora_tx_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  // Accept whenever the held beat is empty or leaving this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_last  <= in_last;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aurora_tx_port_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS CHDR streams onto the Aurora TX stream.
// Define AURORA_TX_PAUSE_EN to add the pause_req/pause_active link-pause handshake.
module aurora_tx_port_arbiter
  import aurora_tx_arb_pkg::*;
#(
  parameter  int CHDR_W    = 64,
  parameter  int NUM_PORTS = 4,
  parameter  int CNT_W     = 32,
  localparam int GP_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        port_enable,
  input  logic [NUM_PORTS*CHDR_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [CHDR_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
`ifdef AURORA_TX_PAUSE_EN
  input  logic                        pause_req,
  output logic                        pause_active,
`endif
  output logic [NUM_PORTS*CNT_W-1:0]  pkt_count,
  output logic [GP_W-1:0]             grant_port
);

  arb_state_e                        state_q, state_d;
  logic [GP_W-1:0]                   grant_q;
  logic [PORT_IDX_W-1:0]             last_q;
  logic [NUM_PORTS-1:0][CHDR_W-1:0]  port_data;
  logic [NUM_PORTS-1:0][CNT_W-1:0]   cnt_q;
  rr_pick_t                          pick;
  logic                              do_grant;
  logic [CHDR_W-1:0]                 sel_data;
  logic                              sel_last, sel_valid, sel_ready;
  logic                              take, eop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_data[i] = s_axis_tdata[i*CHDR_W +: CHDR_W];
  end

  assign pick = next_rr_port(MAX_PORTS'(s_axis_tvalid & port_enable), last_q, NUM_PORTS);

  // Only the granted port feeds the output stage, and only while in PASS.
  assign sel_data  = port_data[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_valid = (state_q == ST_PASS) && s_axis_tvalid[grant_q];
  assign take      = sel_valid && sel_ready;
  assign eop       = take && sel_last;

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d  = ST_PASS;
          do_grant = 1'b1;
        end
`ifdef AURORA_TX_PAUSE_EN
        // Pause is only honoured between packets, so it outranks a new grant here.
        if (pause_req) begin
          state_d  = ST_PAUSED;
          do_grant = 1'b0;
        end
`endif
      end
      ST_PASS: begin
        if (eop) state_d = ST_IDLE;
      end
`ifdef AURORA_TX_PAUSE_EN
      ST_PAUSED: begin
        if (!pause_req) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= PORT_IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        grant_q <= GP_W'(pick.port);
        last_q  <= pick.port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (eop) cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ST_PASS) s_axis_tready[grant_q] = sel_ready;
  end

  aurora_tx_out_reg #(.W(CHDR_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_data),
    .in_last   (sel_last),
    .in_valid  (sel_valid),
    .in_ready  (sel_ready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign pkt_count  = cnt_q;
  assign grant_port = grant_q;
`ifdef AURORA_TX_PAUSE_EN
  assign pause_active = (state_q == ST_PAUSED);
`endif

endmodule

// File: tb/tb_aurora_tx_port_arbiter.sv
// Directed scoreboard bench for aurora_tx_port_arbiter (4 ports, 64-bit data, 4-bit counters).
module tb_aurora_tx_port_arbiter;

  localparam int CHDR_W    = 64;
  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = 4;
  localparam int GP_W      = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_PORTS-1:0]        port_enable;
  logic [NUM_PORTS*CHDR_W-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [CHDR_W-1:0]           m_axis_tdata;
  logic                        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [NUM_PORTS*CNT_W-1:0]  pkt_count;
  logic [GP_W-1:0]             grant_port;
`ifdef AURORA_TX_PAUSE_EN
  logic                        pause_req, pause_active;
`endif

  aurora_tx_port_arbiter #(.CHDR_W(CHDR_W), .NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .port_enable   (port_enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef AURORA_TX_PAUSE_EN
    .pause_req     (pause_req),
    .pause_active  (pause_active),
`endif
    .pkt_count     (pkt_count),
    .grant_port    (grant_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, n_out = 0, first_out = -1, last_out = 0;
  int src_pkts[NUM_PORTS], src_len[NUM_PORTS], src_beat[NUM_PORTS], src_pnum[NUM_PORTS];
  int exp_pnum[NUM_PORTS];
  logic [NUM_PORTS-1:0] pend;
  bit sb_off = 0, bp_toggle = 0, en_hook = 0, pause_hook = 0, prev_stall = 0;
  logic [63:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] mk(input int port, input int pnum, input int beat);
    return {16'(port), 16'(pnum), 32'(beat)};
  endfunction

  task automatic push_pkt(input int port, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back('{mk(port, exp_pnum[port], b), b == len - 1});
    exp_pnum[port]++;
  endtask

  task automatic src_clear();
    for (int i = 0; i < NUM_PORTS; i++) begin
      src_pkts[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_pnum[i] = 0; exp_pnum[i] = 0;
    end
    pend = '0;
  endtask

  function automatic bit src_busy();
    bit b = 0;
    for (int i = 0; i < NUM_PORTS; i++) if (src_pkts[i] > 0) b = 1;
    return b;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tvalid[i] = (src_pkts[i] > 0);
      s_axis_tlast[i]  = (src_beat[i] == src_len[i] - 1);
      s_axis_tdata[i*CHDR_W +: CHDR_W] = mk(i, src_pnum[i], src_beat[i]);
    end
  endtask

  // One clock: retire last cycle's handshakes, drive, then check the settled outputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pend[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0; src_pnum[i]++; src_pkts[i]--;
        end else src_beat[i]++;
      end
    end
    drive_srcs();
    if (bp_toggle) m_axis_tready = ~m_axis_tready;
    if (en_hook && src_pkts[1] > 0 && src_beat[1] == 2) begin
      port_enable[1] = 1'b0; en_hook = 0;
    end
`ifdef AURORA_TX_PAUSE_EN
    if (pause_hook && src_pkts[2] > 0 && src_beat[2] == 1) begin
      pause_req = 1'b1; pause_hook = 0;
    end
`endif
    #1;
    if (rst_n && !sb_off) begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1'b1);
        chk("stall_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("spurious_beat", m_axis_tvalid, 1'b0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e.data);
          chk("beat_last", m_axis_tlast, e.last);
        end
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end else prev_stall = 0;
    pend = rst_n ? (s_axis_tvalid & s_axis_tready) : '0;
  endtask

  task automatic drain(input string tag, input int budget, input bit need_idle);
    int k = 0;
    while (k < budget && (exp_q.size() != 0 || (need_idle && src_busy()))) begin
      step(); k++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int n0, k;
    rst_n = 1'b0; port_enable = '1; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tlast = '0; s_axis_tvalid = '0;
`ifdef AURORA_TX_PAUSE_EN
    pause_req = 1'b0;
`endif
    src_clear();
    step(); step();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tready", s_axis_tready, '0);
    chk("rst_grant", grant_port, '0);
    chk("rst_count", pkt_count, '0);
`ifdef AURORA_TX_PAUSE_EN
    chk("rst_pause_active", pause_active, 1'b0);
`endif
    rst_n = 1'b1;
    step();

    // Round robin: four ports, two 3-beat packets each.
    for (int p = 0; p < NUM_PORTS; p++) begin src_len[p] = 3; src_pkts[p] = 2; end
    for (int r = 0; r < 2; r++) for (int p = 0; p < NUM_PORTS; p++) push_pkt(p, 3);
    first_out = -1;
    drain("rr", 120, 1);
    chk("rr_span", last_out - first_out, 30);
    chk("rr_count", pkt_count, 16'h2222);

    // Backpressure on an 8-beat port-2 packet.
    src_len[2] = 8; src_pkts[2] = 1; push_pkt(2, 8);
    bp_toggle = 1;
    drain("bp", 100, 1);
    bp_toggle = 0; m_axis_tready = 1'b1;
    chk("bp_count", pkt_count, 16'h2322);

    // Enable dropped mid-packet on port 1.
    src_len[1] = 5; src_pkts[1] = 2; push_pkt(1, 5); en_hook = 1;
    drain("en", 60, 0);
    n0 = n_out;
    repeat (10) step();
    chk("en_masked_beats", n_out - n0, 0);
    chk("en_masked_ready", s_axis_tready, '0);
    src_len[0] = 2; src_pkts[0] = 1; push_pkt(0, 2);
    drain("en_other", 40, 0);
    chk("en_other_grant", grant_port, 0);
    port_enable[1] = 1'b1; push_pkt(1, 5);
    drain("en_resume", 60, 1);
    chk("en_count", pkt_count, 16'h2343);

`ifdef AURORA_TX_PAUSE_EN
    // Pause raised inside a port-2 packet; ports 3 and 0 wait behind it.
    src_len[2] = 4; src_pkts[2] = 1; src_len[3] = 2; src_pkts[3] = 1;
    src_len[0] = 2; src_pkts[0] = 1;
    push_pkt(2, 4); push_pkt(3, 2); push_pkt(0, 2); pause_hook = 1;
    k = 0;
    while (k < 60 && exp_q.size() > 4) begin step(); k++; end
    chk("pause_pkt_done", exp_q.size(), 4);
    step();
    chk("pause_active_on", pause_active, 1'b1);
    n0 = n_out;
    repeat (20) step();
    chk("pause_no_beats", n_out - n0, 0);
    chk("pause_no_ready", s_axis_tready, '0);
    chk("pause_held", pause_active, 1'b1);
    pause_req = 1'b0;
    step();
    chk("pause_active_off", pause_active, 1'b0);
    drain("pause_resume", 60, 1);
    chk("pause_count", pkt_count, 16'h3444);
`endif

    // Reset during beat 3 of a port-2 packet.
    src_len[2] = 6; src_pkts[2] = 1; sb_off = 1;
    k = 0;
    while (k < 40 && src_beat[2] != 3) begin step(); k++; end
    chk("rst_mid_reached", src_beat[2], 3);
    rst_n = 1'b0; src_clear(); drive_srcs();
    step();
    rst_n = 1'b1; sb_off = 0;
    chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid_count", pkt_count, '0);
    chk("rst_mid_ready", s_axis_tready, '0);
    src_len[0] = 2; src_pkts[0] = 1; src_len[3] = 2; src_pkts[3] = 1;
    push_pkt(0, 2); push_pkt(3, 2);
    drain("rst_next", 40, 1);
    chk("rst_next_count", pkt_count, 16'h1001);

    // 17 single-beat packets on port 0 wrap a 4-bit counter to 1.
    rst_n = 1'b0; src_clear(); drive_srcs();
    step();
    rst_n = 1'b1;
    src_len[0] = 1; src_pkts[0] = 17;
    for (int n = 0; n < 17; n++) push_pkt(0, 1);
    drain("wrap", 200, 1);
    chk("wrap_count0", pkt_count[3:0], 1);
    chk("wrap_count_all", pkt_count, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
